// File: rtl/exec_mem_unit.sv
// exec_mem_unit -- execute/memory datapath slice of the 5-stage MIPS pipeline.
//
// Purpose:
//   ALU-control decoder (ALUOp + funct -> 4-bit op), 32-bit combinational ALU
//   with zero flag, and a word-addressed data memory (synchronous write,
//   combinational read). The ALU half lives in EX; the memory half is driven
//   from the EX/MEM register in MEM.
//
// Optional feature:
//   `define ALU_SHIFT_EN to decode sll/srl/sra (funct 000000/000010/000011)
//   and use shamt. Without it those functs decode to 1111 and shamt is ignored.
//
// Parameters:
//   DEPTH  number of 32-bit memory words (power of two)
//   AW     word-address width, log2(DEPTH)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (clears memory)
//   alu_op      ALUOp from main control
//   funct       instruction bits [5:0]
//   shamt       instruction bits [10:6]
//   alu_a       forwarded rs operand
//   alu_b       forwarded rt / immediate operand
//   alu_ctrl    decoded ALU operation
//   alu_result  ALU result
//   alu_zero    high when alu_result == 0
//   mem_addr    byte address
//   mem_read    MemRead
//   mem_write   MemWrite
//   mem_wdata   store data
//   mem_rdata   load data (0 when mem_read is low)

module exec_mem_unit #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  // ALU operation encodings
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  // R-type funct encodings
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  logic [3:0] w_funct_op;

  always_comb begin
    w_funct_op = OP_BAD;
    case (funct)
      F_ADD:   w_funct_op = OP_ADD;
      F_SUB:   w_funct_op = OP_SUB;
      F_AND:   w_funct_op = OP_AND;
      F_OR:    w_funct_op = OP_OR;
      F_XOR:   w_funct_op = OP_XOR;
      F_NOR:   w_funct_op = OP_NOR;
      F_SLT:   w_funct_op = OP_SLT;
`ifdef ALU_SHIFT_EN
      F_SLL:   w_funct_op = OP_SLL;
      F_SRL:   w_funct_op = OP_SRL;
      F_SRA:   w_funct_op = OP_SRA;
`endif
      default: w_funct_op = OP_BAD;
    endcase
  end

  always_comb begin
    alu_ctrl = OP_BAD;
    case (alu_op)
      2'b00:   alu_ctrl = OP_ADD;
      2'b01:   alu_ctrl = OP_SUB;
      2'b10:   alu_ctrl = w_funct_op;
      2'b11:   alu_ctrl = OP_OR;
      default: alu_ctrl = OP_BAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_lt;

  assign w_sum  = alu_a + alu_b;
  assign w_diff = alu_a - alu_b;
  assign w_lt   = ($signed(alu_a) < $signed(alu_b));

  always_comb begin
    alu_result = 32'h0;
    case (alu_ctrl)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_ADD:  alu_result = w_sum;
      OP_SUB:  alu_result = w_diff;
      OP_SLT:  alu_result = {31'h0, w_lt};
`ifdef ALU_SHIFT_EN
      OP_SLL:  alu_result = alu_b << shamt;
      OP_SRL:  alu_result = alu_b >> shamt;
      OP_SRA:  alu_result = $signed(alu_b) >>> shamt;
`endif
      default: alu_result = 32'h0;
    endcase
  end

  assign alu_zero = (alu_result == 32'h0);

`ifndef ALU_SHIFT_EN
  // shamt only matters for shifts; keep it visibly consumed.
  logic w_unused_shamt;
  assign w_unused_shamt = ^shamt;
`endif

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  // Byte-offset bits and everything above the index are dropped, so accesses
  // are always word aligned and addresses wrap modulo DEPTH*4.
  logic [AW-1:0] w_idx;
  logic [31:0]   r_mem [DEPTH];
  logic          w_unused_addr;

  assign w_idx         = mem_addr[AW+1:2];
  assign w_unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
    end else if (mem_write) begin
      r_mem[w_idx] <= mem_wdata;
    end
  end

  // Read is straight off the array: same-index write shows up only after the edge.
  assign mem_rdata = mem_read ? r_mem[w_idx] : 32'h0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed testbench for exec_mem_unit (default DEPTH=64, AW=6).
module tb_exec_mem_unit;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_pass = 0;
  int n_tot  = 0;

  exec_mem_unit #(.DEPTH(DEPTH), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_op(alu_op), .funct(funct), .shamt(shamt),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    // during reset: memory reads 0, ALU still works
    @(negedge clk);
    mem_read = 1'b1; mem_addr = 32'd0;
    alu_op = 2'b00; alu_a = 32'd2; alu_b = 32'd3;
    #1;
    n_tot++;
    if (mem_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp %h", mem_rdata, 32'h0);
    else n_pass++;
    n_tot++;
    if (alu_result !== 32'd5) $display("FAIL reset_alu got %h exp %h", alu_result, 32'd5);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tot++;
    if (mem_rdata !== 32'h0) $display("FAIL post_reset_rdata got %h exp %h", mem_rdata, 32'h0);
    else n_pass++;
  endtask

  task automatic test_decode;
    logic [1:0] ops   [12];
    logic [5:0] fns   [12];
    logic [3:0] exps  [12];
    ops = '{2'b00, 2'b01, 2'b11, 2'b00,
            2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    fns = '{6'b000000, 6'b000000, 6'b000000, 6'b100100,
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010, 6'b111111};
    exps = '{4'b0010, 4'b0110, 4'b0001, 4'b0010,
             4'b0010, 4'b0110, 4'b0000, 4'b0001,
             4'b0011, 4'b1100, 4'b0111, 4'b1111};
    alu_a = 32'h1234; alu_b = 32'h5678;
    for (int i = 0; i < 12; i++) begin
      alu_op = ops[i]; funct = fns[i];
      #1;
      n_tot++;
      if (alu_ctrl !== exps[i])
        $display("FAIL decode[%0d] op=%b funct=%b got %b exp %b", i, ops[i], fns[i], alu_ctrl, exps[i]);
      else n_pass++;
    end
    // invalid funct: result 0, zero 1
    n_tot++;
    if (alu_result !== 32'h0 || alu_zero !== 1'b1)
      $display("FAIL bad_funct got res=%h z=%b exp res=0 z=1", alu_result, alu_zero);
    else n_pass++;
  endtask

  task automatic test_alu;
    logic [5:0]  fns [9];
    logic [31:0] as  [9];
    logic [31:0] bs  [9];
    logic [31:0] rs  [9];
    logic        zs  [9];
    fns = '{6'b100000, 6'b100010, 6'b101010, 6'b101010, 6'b100111,
            6'b100110, 6'b100100, 6'b100101, 6'b100010};
    as  = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'd0,
            32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd9};
    bs  = '{32'd1, 32'd7, 32'd1, 32'hFFFF_FFFF, 32'd0,
            32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'd9};
    rs  = '{32'h0, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'hFFFF_FFFF,
            32'h0FF0_0FF0, 32'hF000_F000, 32'hFFF0_FFF0, 32'h0};
    zs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    alu_op = 2'b10;
    for (int i = 0; i < 9; i++) begin
      funct = fns[i]; alu_a = as[i]; alu_b = bs[i];
      #1;
      n_tot++;
      if (alu_result !== rs[i] || alu_zero !== zs[i])
        $display("FAIL alu[%0d] got res=%h z=%b exp res=%h z=%b", i, alu_result, alu_zero, rs[i], zs[i]);
      else n_pass++;
    end
    // beq path: alu_op 01 subtracts
    alu_op = 2'b01; alu_a = 32'd4; alu_b = 32'd4;
    #1;
    n_tot++;
    if (alu_zero !== 1'b1) $display("FAIL beq_zero got %b exp 1", alu_zero);
    else n_pass++;
  endtask

  task automatic test_mem;
    @(negedge clk);
    mem_addr = 32'd8; mem_wdata = 32'hDEAD_BEEF; mem_write = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b1;
    #1;
    n_tot++;
    if (mem_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_8 got %h exp %h", mem_rdata, 32'hDEAD_BEEF);
    else n_pass++;
    mem_addr = 32'd9; #1;
    n_tot++;
    if (mem_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_9 got %h exp %h", mem_rdata, 32'hDEAD_BEEF);
    else n_pass++;
    mem_addr = 32'd8 + 32'(4 * DEPTH); #1;
    n_tot++;
    if (mem_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_wrap got %h exp %h", mem_rdata, 32'hDEAD_BEEF);
    else n_pass++;
    mem_addr = 32'd12; #1;
    n_tot++;
    if (mem_rdata !== 32'h0) $display("FAIL lw_12 got %h exp %h", mem_rdata, 32'h0);
    else n_pass++;
    mem_addr = 32'd8; mem_read = 1'b0; #1;
    n_tot++;
    if (mem_rdata !== 32'h0) $display("FAIL read_off got %h exp %h", mem_rdata, 32'h0);
    else n_pass++;
  endtask

  task automatic test_same_index;
    @(negedge clk);
    mem_addr = 32'd16; mem_wdata = 32'hA5A5_0001; mem_write = 1'b1; mem_read = 1'b1;
    #1;
    n_tot++;
    if (mem_rdata !== 32'h0) $display("FAIL rw_old got %h exp %h", mem_rdata, 32'h0);
    else n_pass++;
    @(posedge clk); #1;
    n_tot++;
    if (mem_rdata !== 32'hA5A5_0001) $display("FAIL rw_new got %h exp %h", mem_rdata, 32'hA5A5_0001);
    else n_pass++;
    mem_write = 1'b0;
  endtask

  task automatic test_reset_mem;
    @(negedge clk);
    mem_addr = 32'd0; mem_wdata = 32'h1234; mem_write = 1'b1; mem_read = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0;
    #1;
    n_tot++;
    if (mem_rdata !== 32'h1234) $display("FAIL pre_reset got %h exp %h", mem_rdata, 32'h1234);
    else n_pass++;
    #1;
    rst_n = 1'b0;   // mid-cycle, asynchronous
    #1;
    n_tot++;
    if (mem_rdata !== 32'h0) $display("FAIL async_clear got %h exp %h", mem_rdata, 32'h0);
    else n_pass++;
    mem_addr = 32'd16; #1;
    n_tot++;
    if (mem_rdata !== 32'h0) $display("FAIL async_clear16 got %h exp %h", mem_rdata, 32'h0);
    else n_pass++;
    // write attempted in reset is dropped
    mem_addr = 32'd0; mem_wdata = 32'h5555; mem_write = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    mem_write = 1'b0;
    rst_n = 1'b1;
    #1;
    n_tot++;
    if (mem_rdata !== 32'h0) $display("FAIL write_in_reset got %h exp %h", mem_rdata, 32'h0);
    else n_pass++;
  endtask

  task automatic test_shift;
    alu_op = 2'b10; alu_a = 32'h0;
    funct = 6'b000000; alu_b = 32'd1; shamt = 5'd31;
    #1;
`ifdef ALU_SHIFT_EN
    n_tot++;
    if (alu_ctrl !== 4'b1000 || alu_result !== 32'h8000_0000)
      $display("FAIL sll got ctrl=%b res=%h exp ctrl=1000 res=80000000", alu_ctrl, alu_result);
    else n_pass++;
    funct = 6'b000011; alu_b = 32'h8000_0000; shamt = 5'd4;
    #1;
    n_tot++;
    if (alu_ctrl !== 4'b1010 || alu_result !== 32'hF800_0000)
      $display("FAIL sra got ctrl=%b res=%h exp ctrl=1010 res=f8000000", alu_ctrl, alu_result);
    else n_pass++;
    funct = 6'b000010;
    #1;
    n_tot++;
    if (alu_ctrl !== 4'b1001 || alu_result !== 32'h0800_0000)
      $display("FAIL srl got ctrl=%b res=%h exp ctrl=1001 res=08000000", alu_ctrl, alu_result);
    else n_pass++;
`else
    n_tot++;
    if (alu_ctrl !== 4'b1111 || alu_result !== 32'h0 || alu_zero !== 1'b1)
      $display("FAIL sll_disabled got ctrl=%b res=%h z=%b exp ctrl=1111 res=0 z=1",
               alu_ctrl, alu_result, alu_zero);
    else n_pass++;
    funct = 6'b000011; alu_b = 32'h8000_0000; shamt = 5'd4;
    #1;
    n_tot++;
    if (alu_ctrl !== 4'b1111 || alu_result !== 32'h0)
      $display("FAIL sra_disabled got ctrl=%b res=%h exp ctrl=1111 res=0", alu_ctrl, alu_result);
    else n_pass++;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    alu_op = 2'b00; funct = 6'h0; shamt = 5'h0; alu_a = 32'h0; alu_b = 32'h0;
    mem_addr = 32'h0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = 32'h0;
    test_reset();
    test_decode();
    test_alu();
    test_mem();
    test_same_index();
    test_reset_mem();
    test_shift();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
Execute/memory datapath slice for the 5-stage MIPS pipeline. It holds three parts:
- ALU-control decoder: maps ALUOp plus funct to a 4-bit ALU operation.
- 32-bit combinational ALU with a zero flag.
- Word-addressed data memory: synchronous write, combinational read.

The ALU half sits in EX; the memory half is driven from the EX/MEM register in MEM.

Parameters:
- DEPTH, 64: number of 32-bit data-memory words; power of two.
- AW, 6: word-address width, equal to log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_op  in  2  ALUOp from main control
- funct  in  6  instruction bits [5:0]
- shamt  in  5  instruction bits [10:6]; used only with the optional feature
- alu_a  in  32  forwarded rs operand
- alu_b  in  32  forwarded rt or immediate operand
- alu_ctrl  out  4  decoded ALU operation
- alu_result  out  32  ALU result
- alu_zero  out  1  high when alu_result == 0
- mem_addr  in  32  byte address (EX/MEM ALU result)
- mem_read  in  1  MemRead
- mem_write  in  1  MemWrite
- mem_wdata  in  32  store data (forwarded rt)
- mem_rdata  out  32  load data

Behaviour:
- ALU control (combinational):
  - alu_op 00 gives 0010 (add, for lw/sw/addi).
  - alu_op 01 gives 0110 (sub, for beq/bne).
  - alu_op 11 gives 0001 (or, for ori).
  - alu_op 10 decodes funct:
    - 100000 add gives 0010
    - 100010 sub gives 0110
    - 100100 and gives 0000
    - 100101 or gives 0001
    - 100110 xor gives 0011
    - 100111 nor gives 1100
    - 101010 slt gives 0111
  - Any other funct gives 1111.
- ALU (combinational, uses alu_ctrl):
  - 0000 a&b; 0001 a|b; 0011 a^b; 1100 ~(a|b).
  - 0010 a+b and 0110 a-b, both mod 2^32 with no overflow trap.
  - 0111 signed compare: result 1 when $signed(a) < $signed(b), else 0.
  - 1111 and all other codes: result 0.
  - alu_zero = (alu_result == 0), including for code 1111.
- Data memory:
  - Word index = mem_addr[AW+1:2]; bits [1:0] ignored (no unaligned access).
  - Upper bits above AW+1 are ignored, so addresses wrap modulo DEPTH*4.
  - Write: on rising clk when mem_write=1, mem[index] <= mem_wdata.
  - Read: mem_rdata = mem[index] when mem_read=1, else 32'h0. Combinational, zero latency.
  - Read and write to the same index in one cycle: mem_rdata shows the old word until the edge and the new word after it (no write-through).
  - mem_read and mem_write both high is legal; the read and write behaviour above is unchanged.
- Reset:
  - rst_n low asynchronously clears all DEPTH words to 0, so mem_rdata is 0 while in reset.
  - Writes are blocked while rst_n is low.
  - A write coincident with reset assertion is lost.
  - The ALU/decoder paths are combinational and unaffected by reset.
- No handshake and no state machine. All outputs settle within the same cycle as their inputs.

Optional Feature:
- Macro ALU_SHIFT_EN.
- When defined:
  - funct 000000 (sll) gives alu_ctrl 1000: result = alu_b << shamt.
  - funct 000010 (srl) gives alu_ctrl 1001: result = alu_b >> shamt, logical.
  - funct 000011 (sra) gives alu_ctrl 1010: result = $signed(alu_b) >>> shamt.
- When undefined: these funct values decode to 1111 (result 0, zero 1), and shamt is ignored.

Test Plan:
- Decode sweep: each alu_op/funct pair listed above → the stated alu_ctrl. alu_op=10 with funct=111111 → 1111, result 0, zero 1.
- Arithmetic: add with a=32'hFFFF_FFFF, b=1 → result 0, zero 1. Sub with a=5, b=7 → 32'hFFFF_FFFE, zero 0.
- slt: a=32'hFFFF_FFFF (-1), b=1 → 1. Swapped operands → 0. Also check nor 0,0 → 32'hFFFF_FFFF and xor.
- Memory: sw of 32'hDEADBEEF to addr 8, then lw addr 8 → DEADBEEF on the next cycle. Same read at addr 9 → DEADBEEF. Read at addr 8+4*DEPTH → DEADBEEF (wrap). mem_read=0 → 0.
- Reset: write 32'h1234 to addr 0, pulse rst_n low mid-cycle → mem_rdata at addr 0 is 0 immediately. A write attempted while rst_n is low leaves the word at 0.
- With ALU_SHIFT_EN: sll of b=1 by 31 → 32'h8000_0000. sra of b=32'h8000_0000 by 4 → 32'hF800_0000. srl of the same → 32'h0800_0000. Without the macro, the same sll → 0.
